// File: rtl/tline_delay.sv
// rtl/tline_delay.sv - multi-channel fixed-delay line with arithmetic-shift loss and valid/ready handshake
// Optional feature: define TLINE_DELAY_FLUSH_EN to add the flush input (clears line contents and pointer).
module tline_delay #(
    parameter int WIDTH       = 16,
    parameter int CHANNELS    = 2,
    parameter int DEPTH       = 8,
    parameter int ATTEN_SHIFT = 0
) (
    input  logic                      clk,
    input  logic                      reset,
`ifdef TLINE_DELAY_FLUSH_EN
    input  logic                      flush,
`endif
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DW    = CHANNELS * WIDTH;

    logic [DW-1:0]    r_buf [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;

    logic             w_xfer;
    logic [PTR_W-1:0] w_ptr_eff;
    logic [PTR_W-1:0] w_ptr_next;
    logic [DW-1:0]    w_tap;
    logic [DW-1:0]    w_atten;

    assign in_ready = !out_valid || out_ready;
    assign w_xfer   = in_valid && in_ready;

    // A flush coincident with a transfer makes that transfer see an empty line at entry 0.
`ifdef TLINE_DELAY_FLUSH_EN
    assign w_ptr_eff = flush ? '0 : r_wr_ptr;
    assign w_tap     = flush ? '0 : r_buf[r_wr_ptr];
`else
    assign w_ptr_eff = r_wr_ptr;
    assign w_tap     = r_buf[r_wr_ptr];
`endif

    assign w_ptr_next = (w_ptr_eff == PTR_W'(DEPTH - 1)) ? '0 : w_ptr_eff + 1'b1;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_atten
        assign w_atten[k*WIDTH +: WIDTH] = $signed(w_tap[k*WIDTH +: WIDTH]) >>> ATTEN_SHIFT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= '0;
            end
            r_wr_ptr  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
`ifdef TLINE_DELAY_FLUSH_EN
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_buf[i] <= '0;
                end
                r_wr_ptr <= '0;
            end
`endif
            // The write below follows the flush clear, so the new sample survives it.
            if (w_xfer) begin
                r_buf[w_ptr_eff] <= in_data;
                r_wr_ptr         <= w_ptr_next;
                out_data         <= w_atten;
                out_valid        <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tline_delay.sv
// tb/tb_tline_delay.sv - self-checking bench for tline_delay (three parameter sets, directed tables and random traffic)
module tb_tline_delay;

    localparam int NDUT = 3;
    localparam int DEP [NDUT] = '{8, 5, 2};
    localparam int SH  [NDUT] = '{0, 0, 2};
    localparam int WD  [NDUT] = '{16, 16, 8};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
`ifdef TLINE_DELAY_FLUSH_EN
    logic        flush = 1'b0;
`endif
    int          s_in [2] = '{0, 0};

    logic [31:0] id_a, id_b, od_a, od_b;
    logic [15:0] id_c, od_c;
    logic        ir [NDUT];
    logic        ov [NDUT];

    assign id_a = {s_in[1][15:0], s_in[0][15:0]};
    assign id_b = {s_in[1][15:0], s_in[0][15:0]};
    assign id_c = {s_in[1][7:0], s_in[0][7:0]};

    always #5 clk = ~clk;

    tline_delay #(.WIDTH(16), .CHANNELS(2), .DEPTH(8), .ATTEN_SHIFT(0)) u_dut_a (
        .clk(clk), .reset(reset),
`ifdef TLINE_DELAY_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(in_valid), .in_ready(ir[0]), .in_data(id_a),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od_a));

    tline_delay #(.WIDTH(16), .CHANNELS(2), .DEPTH(5), .ATTEN_SHIFT(0)) u_dut_b (
        .clk(clk), .reset(reset),
`ifdef TLINE_DELAY_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(in_valid), .in_ready(ir[1]), .in_data(id_b),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od_b));

    tline_delay #(.WIDTH(8), .CHANNELS(2), .DEPTH(2), .ATTEN_SHIFT(2)) u_dut_c (
        .clk(clk), .reset(reset),
`ifdef TLINE_DELAY_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(in_valid), .in_ready(ir[2]), .in_data(id_c),
        .out_valid(ov[2]), .out_ready(out_ready), .out_data(od_c));

    // Reference: each line is a FIFO of the last DEPTH accepted samples, pre-charged with zeros.
    int  line [NDUT][2][$];
    int  m_data [NDUT][2];
    bit  m_valid;
    int  n_checks = 0;
    int  n_pass = 0;

    typedef struct {
        int i0;
        int i1;
        int e0;
        int e1;
    } vec_t;
    vec_t tbl [12];

    function automatic int trunc(int v, int w);
        logic [31:0] t;
        t = v;
        if (w == 8) return int'($signed(t[7:0]));
        return int'($signed(t[15:0]));
    endfunction

    function automatic int get_ch(int d, int k);
        case (d)
            0:       return int'($signed(od_a[k*16 +: 16]));
            1:       return int'($signed(od_b[k*16 +: 16]));
            default: return int'($signed(od_c[k*8 +: 8]));
        endcase
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    task automatic recharge();
        for (int d = 0; d < NDUT; d++)
            for (int k = 0; k < 2; k++) begin
                line[d][k].delete();
                repeat (DEP[d]) line[d][k].push_back(0);
            end
    endtask

    task automatic compare_all();
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("in_ready[%0d]", d), int'(ir[d]), int'(!m_valid || out_ready));
            chk($sformatf("out_valid[%0d]", d), int'(ov[d]), int'(m_valid));
            for (int k = 0; k < 2; k++)
                chk($sformatf("out_data[%0d][%0d]", d, k), get_ch(d, k), m_data[d][k]);
        end
    endtask

    // Advance the model with the inputs currently applied, clock once, compare at the falling edge.
    task automatic tick();
        bit rdy;
        rdy = !m_valid || out_ready;
        if (reset) begin
            recharge();
            m_valid = 1'b0;
            for (int d = 0; d < NDUT; d++) m_data[d] = '{0, 0};
        end else begin
`ifdef TLINE_DELAY_FLUSH_EN
            if (flush) recharge();
`endif
            if (in_valid && rdy) begin
                for (int d = 0; d < NDUT; d++)
                    for (int k = 0; k < 2; k++) begin
                        m_data[d][k] = line[d][k].pop_front() >>> SH[d];
                        line[d][k].push_back(trunc(s_in[k], WD[d]));
                    end
                m_valid = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input bit v, input int d0, input int d1, input bit ordy);
        in_valid  = v;
        s_in[0]   = d0;
        s_in[1]   = d1;
        out_ready = ordy;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 1);
        tick();
        reset = 1'b0;
    endtask

    int held;

    initial begin
        for (int n = 0; n < 12; n++) begin
            tbl[n].i0 = n + 1;
            tbl[n].i1 = -(n + 1);
            tbl[n].e0 = (n < 8) ? 0 : n - 7;
            tbl[n].e1 = -tbl[n].e0;
        end
        recharge();
        m_valid = 1'b0;
        for (int d = 0; d < NDUT; d++) m_data[d] = '{0, 0};

        // Reset state
        do_reset();
        for (int d = 0; d < NDUT; d++) begin
            chk("reset_out_valid", int'(ov[d]), 0);
            chk("reset_in_ready", int'(ir[d]), 1);
            chk("reset_out_data", get_ch(d, 0), 0);
        end

        // Defaults: 1..12 / -1..-12 through an 8-deep line
        for (int n = 0; n < 12; n++) begin
            drive(1, tbl[n].i0, tbl[n].i1, 1);
            tick();
            chk("tbl_valid", int'(ov[0]), 1);
            chk("tbl_ch0", get_ch(0, 0), tbl[n].e0);
            chk("tbl_ch1", get_ch(0, 1), tbl[n].e1);
        end
        drive(0, 0, 0, 1);
        tick();
        chk("drain_valid", int'(ov[0]), 0);

        // DEPTH=5 ramp, pointer wraps twice
        do_reset();
        for (int n = 0; n < 13; n++) begin
            drive(1, 10 * (n + 1), 0, 1);
            tick();
            chk("ramp_d5", get_ch(1, 0), (n < 5) ? 0 : 10 * (n - 4));
        end

        // Back-pressure: output held, no acceptance, then in-order resume
        drive(0, 0, 0, 0);
        tick();
        held = get_ch(0, 0);
        for (int c = 0; c < 4; c++) begin
            drive(1, 500 + c, 0, 0);
            tick();
            chk("stall_in_ready", int'(ir[0]), 0);
            chk("stall_hold", get_ch(0, 0), held);
        end
        for (int n = 0; n < 6; n++) begin
            drive(1, 600 + n, 0, 1);
            tick();
        end

        // WIDTH=8, ATTEN_SHIFT=2 on a 2-deep line: 100 -> 25, -7 -> -2
        do_reset();
        drive(1, 100, -7, 1); tick();
        drive(1, -7, 100, 1); tick();
        drive(1, 0, 0, 1);    tick();
        chk("atten_pos", get_ch(2, 0), 25);
        chk("atten_neg", get_ch(2, 1), -2);
        tick();
        chk("atten_neg2", get_ch(2, 0), -2);

        // Reset mid-stream with pending output and in_valid high
        for (int n = 0; n < 10; n++) begin
            drive(1, 33 + n, -33 - n, 1);
            tick();
        end
        drive(1, 77, 77, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset_valid", int'(ov[0]), 0);
        for (int n = 0; n < 8; n++) begin
            drive(1, 900 + n, 0, 1);
            tick();
            chk("post_reset_zero", get_ch(0, 0), 0);
        end

`ifdef TLINE_DELAY_FLUSH_EN
        // Flush with a pending unaccepted 42: still delivered, line restarts empty
        do_reset();
        for (int n = 0; n < 9; n++) begin
            drive(1, 42, 42, 1);
            tick();
        end
        drive(0, 0, 0, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_keep_valid", int'(ov[0]), 1);
        chk("flush_keep_data", get_ch(0, 0), 42);
        for (int n = 0; n < 8; n++) begin
            drive(1, 7, 7, 1);
            tick();
            chk("post_flush_zero", get_ch(0, 0), 0);
        end
        drive(1, 5, 5, 1);
        tick();
        chk("post_flush_first", get_ch(0, 0), 7);
`endif

        // Random traffic with occasional resets
        do_reset();
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 3) != 0), int'($urandom), int'($urandom),
                  ($urandom_range(0, 3) != 0));
            reset = ($urandom_range(0, 59) == 0);
`ifdef TLINE_DELAY_FLUSH_EN
            flush = ($urandom_range(0, 39) == 0);
`endif
            tick();
        end
        reset = 1'b0;
`ifdef TLINE_DELAY_FLUSH_EN
        flush = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tline_delay.md
TLINE_DELAY -- requirements
Module: tline_delay

Interface
REQ-001 SHALL have parameter WIDTH, default 16, signed sample width per channel (4..32).
REQ-002 SHALL have parameter CHANNELS, default 2, number of independent lines (1..8).
REQ-003 SHALL have parameter DEPTH, default 8, line delay in accepted samples (1..64).
REQ-004 SHALL have parameter ATTEN_SHIFT, default 0, line loss as arithmetic right shift (0..WIDTH-1).
REQ-005 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1, an input sample vector is offered.
REQ-008 SHALL have port in_ready, output, 1, the block accepts the offered vector this cycle.
REQ-009 SHALL have port in_data, input, CHANNELS*WIDTH, channel k in bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port out_valid, output, 1, out_data holds a valid vector.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts out_data this cycle.
REQ-012 SHALL have port out_data, output, CHANNELS*WIDTH, delayed, attenuated vector, same packing.

Function
REQ-013 SHALL accept an input on any cycle with in_valid && in_ready (a "transfer").
REQ-014 SHALL drive in_ready = !out_valid || out_ready, combinationally; no other stall source.
REQ-015 SHALL keep per channel a circular buffer of DEPTH samples plus one shared write pointer, 0..DEPTH-1.
REQ-016 SHALL, on a transfer, load the output register with the buffer entry at the write pointer, write in_data there, and advance the pointer.
REQ-017 SHALL wrap the write pointer from DEPTH-1 to 0; DEPTH need not be a power of two.
REQ-018 SHALL make the output for the n-th transfer equal to input n-DEPTH, or zero for n < DEPTH (uncharged line).
REQ-019 SHALL apply ATTEN_SHIFT per channel as signed arithmetic right shift (rounds toward minus infinity, sign-extended); ATTEN_SHIFT=0 is identity.
REQ-020 SHALL present the result with out_valid high in the cycle after the transfer (latency 1).
REQ-021 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-022 SHALL clear out_valid after an output handshake unless a new transfer occurs the same cycle; back-to-back transfers sustain one vector per cycle.
REQ-023 SHALL treat channels identically and independently; no cross-channel arithmetic.
REQ-024 SHALL not advance the pointer or alter the buffer on cycles without a transfer.

Reset
REQ-025 SHALL, with reset high at a clock edge, clear all buffer entries to 0, the write pointer to 0, out_valid to 0, and out_data to 0.
REQ-026 SHALL discard a pending output and any transfer coincident with reset; reset dominates.
REQ-027 SHALL drive in_ready = 1 during and after reset (out_valid is 0).

Configuration
REQ-028 SHALL, when TLINE_DELAY_FLUSH_EN is defined, add input port flush (1 bit) after reset in the port list.
REQ-029 SHALL, with flush high at a clock edge and reset low, zero all buffer entries and the write pointer while leaving out_valid/out_data and their handshake unaffected; a transfer in the same cycle is accepted and treated as the first transfer after flush (outputs zero, writes entry 0).
REQ-030 SHALL, without TLINE_DELAY_FLUSH_EN, have no flush port and no flush logic; behaviour is otherwise identical.

Verification
REQ-031 SHALL cover: defaults, out_ready=1, inputs 1..12 on ch0 and -1..-12 on ch1 -> eight zero outputs, then 1,2,3,4 / -1,-2,-3,-4 one cycle after each transfer.
REQ-032 SHALL cover: DEPTH=5, 13 transfers of ramp 10,20,... -> zeros for transfers 0..4, then 10,20,...,80; pointer wraps twice without glitch.
REQ-033 SHALL cover: ATTEN_SHIFT=2, WIDTH=8, delayed samples 100 and -7 -> outputs 25 and -2.
REQ-034 SHALL cover: out_ready low 4 cycles with out_valid high -> in_ready low, out_data unchanged, no pointer advance; out_ready high -> one vector per cycle resumes in order.
REQ-035 SHALL cover: reset asserted mid-stream with in_valid high and output pending -> out_valid 0 next cycle, next DEPTH outputs zero.
REQ-036 SHALL cover (TLINE_DELAY_FLUSH_EN): flush with pending output 42 unaccepted -> 42 still delivered; subsequent DEPTH outputs zero.
